// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_if
//  Description : FIFO read port between the TX FIFO and the UART serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if #(
    parameter int DATA_SIZE = 8
) ();
    logic                 fifo_empty;
    logic [DATA_SIZE-1:0] fifo_rd_data;
    logic                 fifo_rd_en;

    // master: the serializer that pops words; slave: the FIFO that supplies them
    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_en
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmit serializer (start, LSB-first data, 1/2 stop)
//                fed directly from a FIFO, with back-to-back frame support.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int DATA_SIZE = 8,
    parameter int DIV_WIDTH = 16
) (
    input  wire                  clock,
    input  wire                  reset,
    input  wire                  tx_en,
    input  wire                  nstop,
    input  wire  [DIV_WIDTH-1:0] div,
    uart_tx_if.master            fifo,
    output logic                 txd,
    output logic                 busy
);

    localparam int c_BIT_W = $clog2(DATA_SIZE + 1);
    localparam logic [c_BIT_W-1:0] c_LAST_DATA_BIT = c_BIT_W'(DATA_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                 state_q,  state_d;
    logic [DIV_WIDTH-1:0]   baud_q,   baud_d;
    logic [c_BIT_W-1:0]     bit_q,    bit_d;
    logic [DATA_SIZE-1:0]   shift_q,  shift_d;
    logic [DIV_WIDTH-1:0]   div_q,    div_d;
    logic                   nstop_q,  nstop_d;
    logic                   txd_q,    txd_d;
    logic                   busy_q,   busy_d;

    logic w_last_baud;
    logic w_stop_done;
    logic w_pop;

    assign w_last_baud = (baud_q == div_q);
    assign w_stop_done = (state_q == S_STOP) && w_last_baud &&
                         (bit_q == {{(c_BIT_W-1){1'b0}}, nstop_q});
    assign w_pop       = tx_en & ~fifo.fifo_empty &
                         ((state_q == S_IDLE) | w_stop_done);

    assign fifo.fifo_rd_en = w_pop & reset;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        div_d   = div_q;
        nstop_d = nstop_q;

        if (w_pop) begin
            // Latch frame settings so mid-frame changes wait for the next word
            state_d = S_START;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = fifo.fifo_rd_data;
            div_d   = div;
            nstop_d = nstop;
        end else begin
            case (state_q)
                S_START: begin
                    if (w_last_baud) begin
                        baud_d  = '0;
                        bit_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        baud_d = baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_last_baud) begin
                        baud_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == c_LAST_DATA_BIT) begin
                            bit_d   = '0;
                            state_d = S_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        baud_d = baud_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_last_baud) begin
                        baud_d = '0;
                        if (w_stop_done) begin
                            bit_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        baud_d = baud_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs are registered from the next state so txd/busy change at the edge
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            div_q   <= '0;
            nstop_q <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            nstop_q <= nstop_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int DATA_SIZE = 8;
    localparam int DIV_WIDTH = 16;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 tx_en = 1'b0;
    logic                 nstop = 1'b0;
    logic [DIV_WIDTH-1:0] div   = 16'd3;
    logic                 txd;
    logic                 busy;

    uart_tx_if #(.DATA_SIZE(DATA_SIZE)) fifo ();

    uart_tx #(.DATA_SIZE(DATA_SIZE), .DIV_WIDTH(DIV_WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .tx_en (tx_en),
        .nstop (nstop),
        .div   (div),
        .fifo  (fifo),
        .txd   (txd),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: pending FIFO words, and the txd level of every remaining busy cycle
    logic [DATA_SIZE-1:0] fifo_q[$];
    logic                 exp_q[$];

    // Per-scenario observations
    int   cnt_busy, cnt_rden, cnt_txd_hi;
    logic txd_log[$];
    int   rden_cyc[$];
    logic s_rden;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo.fifo_empty   = (fifo_q.size() == 0);
        fifo.fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : DATA_SIZE'($urandom);
    endtask

    task automatic push(input logic [DATA_SIZE-1:0] d);
        fifo_q.push_back(d);
        drive_fifo();
    endtask

    task automatic clr_stats();
        cnt_busy = 0; cnt_rden = 0; cnt_txd_hi = 0;
        txd_log.delete();
        rden_cyc.delete();
    endtask

    // One clock cycle: compare at negedge, then update the FIFO just after posedge
    task automatic cycle();
        logic exp_txd, exp_busy, exp_pop;
        logic [DATA_SIZE-1:0] w;
        @(negedge clock);
        exp_busy = (exp_q.size() > 0);
        exp_txd  = exp_busy ? exp_q[0] : 1'b1;
        exp_pop  = reset && tx_en && (fifo_q.size() > 0) && (exp_q.size() <= 1);
        chk("txd", {31'd0, txd}, {31'd0, exp_txd});
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        chk("fifo_rd_en", {31'd0, fifo.fifo_rd_en}, {31'd0, exp_pop});
        s_rden = fifo.fifo_rd_en;
        if (busy) begin
            cnt_busy++;
            txd_log.push_back(txd);
        end
        if (txd) cnt_txd_hi++;
        if (fifo.fifo_rd_en) begin
            cnt_rden++;
            rden_cyc.push_back(cyc);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (exp_pop) begin
            w = fifo_q[0];
            for (int b = 0; b < DATA_SIZE + 3; b++) begin
                logic lvl;
                if (b == DATA_SIZE + 2 && !nstop) break;
                if (b == 0)              lvl = 1'b0;
                else if (b <= DATA_SIZE) lvl = w[b-1];
                else                     lvl = 1'b1;
                for (int k = 0; k <= int'(div); k++) exp_q.push_back(lvl);
            end
        end
        cyc++;
        @(posedge clock);
        #1;
        if (exp_pop) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic [9:0]  pat_a5;
        logic [7:0]  dec;
        logic [7:0]  pushed[3];

        fifo.fifo_empty   = 1'b1;
        fifo.fifo_rd_data = '0;
        clr_stats();

        // Reset state
        run(3);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rden", {31'd0, fifo.fifo_rd_en}, 32'd0);
        reset = 1'b1;
        run(2);

        // Single byte, one stop bit
        div = 16'd3; nstop = 1'b0;
        clr_stats();
        push(8'hA5);
        tx_en = 1'b1;
        run(45);
        chk("a5_busy_len", cnt_busy, 32'd40);
        chk("a5_rden_cnt", cnt_rden, 32'd1);
        pat_a5 = 10'b1101001010;
        for (int i = 0; i < 40; i++)
            chk("a5_txd_bit", {31'd0, txd_log[i]}, {31'd0, pat_a5[i/4]});

        // Back-to-back frames
        clr_stats();
        push(8'h00);
        push(8'hFF);
        run(90);
        chk("b2b_rden_cnt", cnt_rden, 32'd2);
        chk("b2b_gap", rden_cyc[1] - rden_cyc[0], 32'd40);
        chk("b2b_busy_len", cnt_busy, 32'd80);
        chk("b2b_empty", {31'd0, fifo.fifo_empty}, 32'd1);

        // Two stop bits, nstop toggled mid-frame
        div = 16'd1; nstop = 1'b1;
        clr_stats();
        push(8'h3C);
        run(5);
        nstop = 1'b0;
        run(25);
        chk("ns2_busy_len", cnt_busy, 32'd22);
        chk("ns2_last_data", {31'd0, txd_log[17]}, 32'd0);
        for (int i = 18; i < 22; i++)
            chk("ns2_stop_hi", {31'd0, txd_log[i]}, 32'd1);

        // Enable gating
        div = 16'd3;
        tx_en = 1'b0;
        clr_stats();
        push(8'h81);
        push(8'h42);
        run(100);
        chk("gate_no_pop", cnt_rden, 32'd0);
        chk("gate_idle_hi", cnt_txd_hi, 32'd100);
        tx_en = 1'b1;
        run(1);
        chk("gate_pop_next", {31'd0, s_rden}, 32'd1);
        run(15);
        tx_en = 1'b0;
        run(60);
        chk("gate_one_pop", cnt_rden, 32'd1);
        chk("gate_busy_fall", {31'd0, busy}, 32'd0);

        // Reset during data bit 3
        push(8'hE7);
        tx_en = 1'b1;
        clr_stats();
        run(18);
        chk("rstmid_popped", cnt_rden, 32'd1);
        reset = 1'b0;
        #1;
        chk("rstmid_txd", {31'd0, txd}, 32'd1);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_rden", {31'd0, fifo.fifo_rd_en}, 32'd0);
        exp_q.delete();
        run(3);
        reset = 1'b1;
        clr_stats();
        run(1);
        chk("rstmid_fresh_pop", {31'd0, s_rden}, 32'd1);
        run(45);
        chk("rstmid_busy_len", cnt_busy, 32'd40);

        // div = 0, three frames back to back
        div = 16'd0;
        pushed[0] = 8'h55; pushed[1] = 8'hAA; pushed[2] = 8'h0F;
        clr_stats();
        for (int i = 0; i < 3; i++) push(pushed[i]);
        run(35);
        chk("d0_busy_len", cnt_busy, 32'd30);
        chk("d0_rden_cnt", cnt_rden, 32'd3);
        chk("d0_gap1", rden_cyc[1] - rden_cyc[0], 32'd10);
        chk("d0_gap2", rden_cyc[2] - rden_cyc[1], 32'd10);
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 8; b++) dec[b] = txd_log[f*10 + 1 + b];
            chk("d0_decode", {24'd0, dec}, {24'd0, pushed[f]});
        end

        // Randomized traffic with mid-frame setting changes
        tx_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0 && fifo_q.size() < 4) push(8'($urandom));
            if ($urandom_range(0, 19) == 0) div = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) nstop = 1'($urandom);
            if ($urandom_range(0, 49) == 0) tx_en = ($urandom_range(0, 4) != 0);
            cycle();
        end
        tx_en = 1'b1;
        run(200);
        chk("final_drained", {31'd0, fifo.fifo_empty}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
